// File: rtl/csr_issue_pkg.sv
// Shared CSR issue definitions: payload layout, issue FSM states and op[1:0] codes.
// The csr unit imports this package too, so the op encoding lives in one place.
package csr_issue_pkg;

   localparam int unsigned OP_W       = 5;
   localparam int unsigned ROBID_W    = 7;
   localparam int unsigned RD_W       = 6;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned CSR_ADDR_W = 12;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_HEAD = 2'd1,
      ST_ISSUE     = 2'd2,
      ST_DRAIN     = 2'd3
   } issue_state_e;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   // Only the 12-bit CSR address of imm is kept; it is zero-extended on issue.
   typedef struct packed {
      logic [OP_W-1:0]       op;
      logic [ROBID_W-1:0]    robid;
      logic [RD_W-1:0]       rd;
      logic [XLEN-1:0]       op1;
      logic [CSR_ADDR_W-1:0] addr;
   } csr_entry_t;

   function automatic csr_op_e csr_op_kind(input logic [OP_W-1:0] op);
      return csr_op_e'(op[1:0]);
   endfunction

endpackage

// File: rtl/csr_issue_fifo.sv
// In-order buffer of dispatched CSR instructions with push/pop/flush.
// Payload storage is left unreset; only pointers, count and flags are reset.
module csr_issue_fifo
   import csr_issue_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  csr_entry_t push_data_i,
   input  logic       pop_i,
   input  logic       flush_i,
   output logic       full_o,
   output logic       empty_o,
   output csr_entry_t head_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   csr_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, empty_q;
   logic             push_ok, pop_ok;

   // A full buffer refuses a push even when the head pops in the same cycle.
   always_comb begin
      push_ok  = push_i && !full_q && !flush_i;
      pop_ok   = pop_i && !empty_q && !flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
         if (pop_ok)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = CNT_W'(count_q + 1'b1);
            2'b01:   count_d = CNT_W'(count_q - 1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == CNT_W'(DEPTH));
         empty_q  <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/csr_issue.sv
// CSR issue stage: buffers CSR instructions from rename and issues the head
// to the csr unit only once it is the oldest instruction in the ROB.
module csr_issue
   import csr_issue_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dispatch_csr_valid,
   input  logic [OP_W-1:0]       dispatch_op,
   input  logic [ROBID_W-1:0]    dispatch_robid,
   input  logic [RD_W-1:0]       dispatch_rd,
   input  logic [XLEN-1:0]       dispatch_op1,
   input  logic [XLEN-1:0]       dispatch_imm,
   output logic                  csr_issue_stall,
   output logic                  rename_csr_write,
   output logic [OP_W-1:0]       rename_op,
   output logic [ROBID_W-1:0]    rename_robid,
   output logic [RD_W-1:0]       rename_rd,
   output logic [XLEN-1:0]       rename_op1,
   output logic [XLEN-1:0]       rename_imm,
   input  logic [ROBID_W-1:0]    rob_head_id,
   input  logic                  rob_flush,
   input  logic                  csr_valid
);

   issue_state_e         state_q, state_d;
   logic [ROBID_W-1:0]   issued_robid_q, issued_robid_d;
   csr_entry_t           push_entry, head;
   logic                 fifo_full, fifo_empty, pop;
   logic                 unused_imm_hi;

   assign push_entry = '{op:    dispatch_op,
                         robid: dispatch_robid,
                         rd:    dispatch_rd,
                         op1:   dispatch_op1,
                         addr:  dispatch_imm[CSR_ADDR_W-1:0]};
   assign unused_imm_hi = ^dispatch_imm[XLEN-1:CSR_ADDR_W];
   assign pop = (state_q == ST_ISSUE);

   csr_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst),
      .push_i      (dispatch_csr_valid),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (rob_flush),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (head)
   );

   assign csr_issue_stall = fifo_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         issued_robid_q <= '0;
      end else begin
         state_q        <= state_d;
         issued_robid_q <= issued_robid_d;
      end
   end

   // DRAIN holds until the ROB head moves off the robid just issued (retired).
   always_comb begin
      state_d        = state_q;
      issued_robid_d = issued_robid_q;
      if (rob_flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:      if (!fifo_empty) state_d = ST_WAIT_HEAD;
            ST_WAIT_HEAD: if (head.robid == rob_head_id && !csr_valid) state_d = ST_ISSUE;
            ST_ISSUE: begin
               issued_robid_d = head.robid;
               state_d        = ST_DRAIN;
            end
            ST_DRAIN:     if (issued_robid_q != rob_head_id) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
         endcase
      end
   end

   // A flush in the ISSUE cycle kills the pulse; data is zero whenever no pulse.
   always_comb begin
      rename_csr_write = 1'b0;
      rename_op        = '0;
      rename_robid     = '0;
      rename_rd        = '0;
      rename_op1       = '0;
      rename_imm       = '0;
      if (state_q == ST_ISSUE && !rob_flush) begin
         rename_csr_write = 1'b1;
         rename_op        = head.op;
         rename_robid     = head.robid;
         rename_rd        = head.rd;
         rename_op1       = head.op1;
         rename_imm       = XLEN'(head.addr);
      end
   end

endmodule

// File: tb/tb_csr_issue.sv
// Bench for csr_issue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_csr_issue;

   localparam int unsigned DEPTH = 2;

   logic        clk, rst;
   logic        dispatch_csr_valid;
   logic [4:0]  dispatch_op;
   logic [6:0]  dispatch_robid;
   logic [5:0]  dispatch_rd;
   logic [31:0] dispatch_op1, dispatch_imm;
   logic        csr_issue_stall, rename_csr_write;
   logic [4:0]  rename_op;
   logic [6:0]  rename_robid;
   logic [5:0]  rename_rd;
   logic [31:0] rename_op1, rename_imm;
   logic [6:0]  rob_head_id;
   logic        rob_flush, csr_valid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   csr_issue #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .dispatch_csr_valid (dispatch_csr_valid),
      .dispatch_op        (dispatch_op),
      .dispatch_robid     (dispatch_robid),
      .dispatch_rd        (dispatch_rd),
      .dispatch_op1       (dispatch_op1),
      .dispatch_imm       (dispatch_imm),
      .csr_issue_stall    (csr_issue_stall),
      .rename_csr_write   (rename_csr_write),
      .rename_op          (rename_op),
      .rename_robid       (rename_robid),
      .rename_rd          (rename_rd),
      .rename_op1         (rename_op1),
      .rename_imm         (rename_imm),
      .rob_head_id        (rob_head_id),
      .rob_flush          (rob_flush),
      .csr_valid          (csr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: buffered instructions in order plus the issue phase.
   typedef struct {
      logic [4:0]  op;
      logic [6:0]  robid;
      logic [5:0]  rd;
      logic [31:0] op1;
      logic [31:0] imm;
   } ent_t;
   typedef enum int {P_IDLE, P_WAIT, P_ISSUE, P_DRAIN} phase_t;

   ent_t       q[$];
   phase_t     ph = P_IDLE;
   logic [6:0] issued = '0;

   always @(negedge clk) begin
      ent_t h;
      logic ew;
      bit   push;
      if (!rst) begin
         q.delete();
         ph = P_IDLE;
      end
      h  = '{default: '0};
      if (q.size() > 0) h = q[0];
      ew = (ph == P_ISSUE) && !rob_flush && rst;
      chk("stall", 32'(csr_issue_stall), 32'(q.size() == DEPTH));
      chk("write", 32'(rename_csr_write), 32'(ew));
      chk("op",    32'(rename_op),    ew ? 32'(h.op)    : 32'd0);
      chk("robid", 32'(rename_robid), ew ? 32'(h.robid) : 32'd0);
      chk("rd",    32'(rename_rd),    ew ? 32'(h.rd)    : 32'd0);
      chk("op1",   rename_op1,        ew ? h.op1        : 32'd0);
      chk("imm",   rename_imm,        ew ? h.imm        : 32'd0);
      if (rst) begin
         if (rob_flush) begin
            q.delete();
            ph = P_IDLE;
         end else begin
            push = dispatch_csr_valid && (q.size() < DEPTH);
            case (ph)
               P_IDLE:  if (q.size() > 0) ph = P_WAIT;
               P_WAIT:  if (q[0].robid == rob_head_id && !csr_valid) ph = P_ISSUE;
               P_ISSUE: begin
                  issued = q[0].robid;
                  void'(q.pop_front());
                  ph = P_DRAIN;
               end
               P_DRAIN: if (issued != rob_head_id) ph = P_IDLE;
               default: ph = P_IDLE;
            endcase
            if (push) q.push_back('{op: dispatch_op, robid: dispatch_robid, rd: dispatch_rd,
                                    op1: dispatch_op1, imm: {20'd0, dispatch_imm[11:0]}});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_pulse(input string name, input logic [6:0] r, output int at);
      int n = 0;
      while (!rename_csr_write && n < 12) begin
         tick();
         n++;
      end
      if (!rename_csr_write) begin
         errors++;
         checks++;
         $display("FAIL %s: no issue pulse within 12 cycles, expected robid %0d", name, r);
         at = cyc;
      end else begin
         chk(name, 32'(rename_robid), 32'(r));
         at = cyc;
      end
   endtask

   task automatic enq(input logic [6:0] r);
      dispatch_csr_valid = 1'b1;
      dispatch_robid     = r;
      dispatch_op        = 5'($urandom);
      dispatch_rd        = 6'($urandom);
      dispatch_op1       = $urandom;
      dispatch_imm       = $urandom;
   endtask

   initial begin
      int at, last_at, npulse;
      rst = 1'b0;
      dispatch_csr_valid = 1'b0;
      dispatch_op = '0; dispatch_robid = '0; dispatch_rd = '0;
      dispatch_op1 = '0; dispatch_imm = '0;
      rob_head_id = '0; rob_flush = 1'b0; csr_valid = 1'b0;
      repeat (3) tick();
      chk("rst_stall", 32'(csr_issue_stall), 32'd0);
      chk("rst_write", 32'(rename_csr_write), 32'd0);
      chk("rst_imm", rename_imm, 32'd0);
      rst = 1'b1;
      tick();

      // single op at ROB head
      rob_head_id = 7'd5;
      enq(7'd5);
      dispatch_op = 5'b00001; dispatch_op1 = 32'h0000_dead; dispatch_imm = 32'hffff_f345;
      tick();
      dispatch_csr_valid = 1'b0;
      chk("t033_c1", 32'(rename_csr_write), 32'd0);
      tick();
      chk("t033_c2", 32'(rename_csr_write), 32'd0);
      tick();
      chk("t033_pulse", 32'(rename_csr_write), 32'd1);
      chk("t033_robid", 32'(rename_robid), 32'd5);
      chk("t033_imm", rename_imm, 32'h0000_0345);
      chk("t033_op1", rename_op1, 32'h0000_dead);
      tick();
      chk("t033_once", 32'(rename_csr_write), 32'd0);
      rob_head_id = 7'd6;
      repeat (3) begin tick(); chk("t033_after", 32'(rename_csr_write), 32'd0); end

      // not at head
      rob_head_id = 7'd3;
      enq(7'd9);
      tick();
      dispatch_csr_valid = 1'b0;
      repeat (10) begin chk("t034_hold", 32'(rename_csr_write), 32'd0); tick(); end
      rob_head_id = 7'd9;
      tick();
      chk("t034_pulse", 32'(rename_csr_write), 32'd1);
      chk("t034_robid", 32'(rename_robid), 32'd9);
      tick();
      rob_head_id = 7'd10;
      tick(); tick();

      // full buffer refuses the third instruction
      rob_head_id = 7'd0;
      enq(7'd1);
      tick();
      enq(7'd2);
      chk("t035_stall0", 32'(csr_issue_stall), 32'd0);
      tick();
      chk("t035_stall1", 32'(csr_issue_stall), 32'd1);
      enq(7'd3);
      tick();
      chk("t035_stall2", 32'(csr_issue_stall), 32'd1);
      tick();
      dispatch_csr_valid = 1'b0;
      rob_head_id = 7'd1;
      wait_pulse("t035_first", 7'd1, at);
      tick();
      rob_head_id = 7'd2;
      wait_pulse("t035_second", 7'd2, at);
      tick();
      rob_head_id = 7'd3;
      repeat (8) begin tick(); chk("t035_refused", 32'(rename_csr_write), 32'd0); end

      // flush during the issue cycle
      rob_head_id = 7'd20;
      enq(7'd20);
      tick();
      dispatch_csr_valid = 1'b0;
      tick(); tick();
      rob_flush = 1'b1;
      enq(7'd21);
      #1;
      chk("t036_suppress", 32'(rename_csr_write), 32'd0);
      tick();
      rob_flush = 1'b0;
      dispatch_csr_valid = 1'b0;
      chk("t036_empty", 32'(csr_issue_stall), 32'd0);
      rob_head_id = 7'd21;
      repeat (6) begin tick(); chk("t036_dropped", 32'(rename_csr_write), 32'd0); end

      // six sequential ops, pointers wrap
      last_at = -100;
      for (int i = 0; i < 6; i++) begin
         rob_head_id = 7'(40 + i);
         enq(7'(40 + i));
         tick();
         dispatch_csr_valid = 1'b0;
         wait_pulse("t037_order", 7'(40 + i), at);
         chk("t037_gap", 32'(at - last_at >= 2), 32'd1);
         last_at = at;
         tick();
      end
      rob_head_id = 7'd60;
      tick(); tick();

      // async reset with two entries buffered
      rob_head_id = 7'd99;
      enq(7'd70);
      tick();
      enq(7'd71);
      tick();
      dispatch_csr_valid = 1'b0;
      chk("t038_full", 32'(csr_issue_stall), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("t038_stall", 32'(csr_issue_stall), 32'd0);
      chk("t038_write", 32'(rename_csr_write), 32'd0);
      tick();
      rst = 1'b1;
      rob_head_id = 7'd70;
      repeat (4) begin tick(); chk("t038_none70", 32'(rename_csr_write), 32'd0); end
      rob_head_id = 7'd71;
      repeat (4) begin tick(); chk("t038_none71", 32'(rename_csr_write), 32'd0); end

      // randomized traffic
      npulse = 0;
      for (int i = 0; i < 3000; i++) begin
         dispatch_csr_valid = 1'($urandom_range(0, 1));
         dispatch_robid     = 7'($urandom_range(0, 7));
         dispatch_op        = 5'($urandom);
         dispatch_rd        = 6'($urandom);
         dispatch_op1       = $urandom;
         dispatch_imm       = $urandom;
         csr_valid          = ($urandom_range(0, 3) == 0);
         rob_flush          = ($urandom_range(0, 39) == 0);
         if (q.size() > 0 && $urandom_range(0, 2) != 0) rob_head_id = q[0].robid;
         else rob_head_id = 7'($urandom_range(0, 7));
         tick();
         if (rename_csr_write) npulse++;
      end
      chk("rand_pulses_seen", 32'(npulse > 50), 32'd1);
      rob_flush = 1'b0;
      dispatch_csr_valid = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_issue.md
CSR_ISSUE -- requirements
Module: csr_issue

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered CSR instructions (power of two, at least 2).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 dispatch_csr_valid  in  1  rename presents a CSR instruction this cycle.
REQ-005 dispatch_op  in  5  op; [1:0] are 00 read-only, 01 write, 10 set, 11 clear.
REQ-006 dispatch_robid  in  7 / dispatch_rd  in  6 / dispatch_op1  in  32 / dispatch_imm  in  32  instruction fields; imm[11:0] is the CSR address.
REQ-007 csr_issue_stall  out  1  buffer full; rename holds the instruction.
REQ-008 rename_csr_write  out  1  one-cycle issue pulse to the csr unit.
REQ-009 rename_op  out  5 / rename_robid  out  7 / rename_rd  out  6 / rename_op1  out  32 / rename_imm  out  32  issued fields; imm is zero-extended from 12 bits.
REQ-010 rob_head_id  in  7  robid currently at the ROB head.
REQ-011 rob_flush  in  1  pipeline flush.
REQ-012 csr_valid  in  1  csr unit busy with the previous issue.

Function
REQ-013 Enqueue occurs when dispatch_csr_valid=1, count<DEPTH and rob_flush=0; an enqueued entry is eligible to issue no earlier than the next cycle.
REQ-014 csr_issue_stall SHALL be combinational and equal to (count==DEPTH).
REQ-015 Issue is strictly in order, and only the head entry issues.
REQ-016 Issue SHALL use FSM IDLE -> WAIT_HEAD -> ISSUE -> DRAIN -> IDLE.
REQ-017 IDLE: go to WAIT_HEAD when count>0.
REQ-018 WAIT_HEAD: go to ISSUE when head.robid==rob_head_id and csr_valid=0.
REQ-019 ISSUE: drive rename_csr_write=~rob_flush with the head fields for exactly one cycle, pop the head at the clock edge, then go to DRAIN.
REQ-020 DRAIN: wait until head.robid!=rob_head_id (the previous CSR has retired), then go to IDLE; this enforces at least two cycles between issues.
REQ-021 When rename_csr_write=0, all rename_* data outputs SHALL be 0.
REQ-022 Count arithmetic: simultaneous enqueue and pop leaves count unchanged; when full, enqueue is refused even if a pop occurs in the same cycle.
REQ-023 Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 rob_flush=1 takes priority over everything: at the edge, count:=0, pointers:=0, FSM:=IDLE, and any enqueue in that cycle is dropped.
REQ-025 A flush in the ISSUE cycle suppresses the rename_csr_write pulse combinationally.
REQ-026 Robid comparison is exact 7-bit equality; no age arithmetic.

Reset
REQ-027 While rst=0: FSM=IDLE, count=0, pointers=0, csr_issue_stall=0, rename_csr_write=0, all rename_* data outputs=0.
REQ-028 Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.
REQ-029 Entry payload storage need not be reset; only valid state is reset.

Structure
REQ-030 FSM state encodings and the op[1:0] codes (read-only, write, set, clear) SHALL live in a shared package, also used by the csr unit.
REQ-031 The buffer SHALL be a sub-module csr_issue_fifo (DEPTH entries, push/pop/flush, full/empty, head output).
REQ-032 The FSM and issue muxing SHALL reside in csr_issue.

Verification
REQ-033 Single op: enqueue robid=5, rob_head_id=5, csr_valid=0 -> rename_csr_write pulses exactly once, 2 cycles after enqueue, with robid=5.
REQ-034 Not at head: enqueue robid=9 while rob_head_id=3 for 10 cycles -> no issue; set rob_head_id=9 -> issue pulse the next cycle.
REQ-035 Full: enqueue robids 1,2,3 back-to-back with DEPTH=2 and rob_head_id=0 -> stall high from the cycle after the second enqueue; robid 3 is refused and held by rename.
REQ-036 Flush: rob_flush asserted in the ISSUE cycle -> rename_csr_write stays 0, count=0 next cycle, and a same-cycle enqueue is dropped.
REQ-037 Wrap-around: 6 sequential ops, each retired by advancing rob_head_id -> issue order matches enqueue order, issues are separated by at least 2 cycles, and pointers wrap cleanly.
REQ-038 Async reset: drop rst with 2 entries buffered, between clock edges -> stall and rename_csr_write go to 0 immediately, and nothing issues after release.
